// File: rtl/mycpu_exe.sv
// EXE stage of the 5-stage pipeline: ALU, data-SRAM request generation and
// the EXE/MEM pipeline register with its forwarding tap.
module mycpu_exe (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_op1,
  input  logic [31:0] id_op2,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_target_reg,
  input  logic [31:0] id_store_cont,
  input  logic [3:0]  id_alu_op,
  input  logic        id_regfile_wen,
  input  logic [5:0]  id_ls_mode,
  input  logic        mem_allow_in,
  output logic        exe_allow_in,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [5:0]  exe_fwd_tag,
  output logic [31:0] exe_fwd_data,
  output logic        exe2mem_valid,
  output logic [31:0] exe2mem_pc,
  output logic [31:0] exe2mem_result,
  output logic [4:0]  exe2mem_target_reg,
  output logic        exe2mem_regfile_wen,
  output logic [5:0]  exe2mem_ls_mode,
  output logic [1:0]  exe2mem_addr_low,
  output logic        exe2mem_ovf
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  tgt;
    logic        wen;
    logic [5:0]  ls;
    logic        ovf;
  } em_t;

  em_t         em_q, em_d;
  logic        vld_q;
  logic [31:0] alu_res, sum, diff;
  logic [4:0]  shamt;
  logic        ovf;
  logic        xfer, fwd_hit;
  logic [1:0]  a;
  logic [3:0]  wen_raw;

  always_comb begin
    sum     = id_op1 + id_op2;
    diff    = id_op1 - id_op2;
    shamt   = id_op1[4:0];
    alu_res = '0;
    ovf     = 1'b0;
    case (id_alu_op)
      4'b0000, 4'b1100: alu_res = sum;
      4'b0001, 4'b1101: alu_res = diff;
      4'b0010: alu_res = {31'b0, $signed(id_op1) < $signed(id_op2)};
      4'b0011: alu_res = {31'b0, id_op1 < id_op2};
      4'b0100: alu_res = id_op1 & id_op2;
      4'b0101: alu_res = id_op1 | id_op2;
      4'b0110: alu_res = id_op1 ^ id_op2;
      4'b0111: alu_res = ~(id_op1 | id_op2);
      4'b1000: alu_res = id_op2 << shamt;
      4'b1010: alu_res = id_op2 >> shamt;
      4'b1011: alu_res = $unsigned($signed(id_op2) >>> shamt);
      default: alu_res = '0;
    endcase
    // signed overflow: operands agree (add) / differ (sub) in sign and result sign flips
    if (id_alu_op == 4'b1100)
      ovf = (id_op1[31] == id_op2[31]) && (sum[31] != id_op1[31]);
    else if (id_alu_op == 4'b1101)
      ovf = (id_op1[31] != id_op2[31]) && (diff[31] != id_op1[31]);
  end

  assign exe_allow_in = !vld_q || mem_allow_in;
  assign xfer         = id_valid && exe_allow_in;

  // Byte lanes and data alignment for B/H/W/WL/WR stores
  always_comb begin
    a               = alu_res[1:0];
    wen_raw         = 4'b0000;
    data_sram_wdata = id_store_cont;
    case (id_ls_mode[3:1])
      3'b000: begin
        wen_raw         = 4'b0001 << a;
        data_sram_wdata = {4{id_store_cont[7:0]}};
      end
      3'b001: begin
        wen_raw         = a[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{id_store_cont[15:0]}};
      end
      3'b010: wen_raw = 4'b1111;
      3'b011: begin
        wen_raw         = 4'b1111 >> (~a);
        data_sram_wdata = id_store_cont >> {~a, 3'b000};
      end
      3'b100: begin
        wen_raw         = 4'b1111 << a;
        data_sram_wdata = id_store_cont << {a, 3'b000};
      end
      default: wen_raw = 4'b0000;
    endcase
  end

  assign data_sram_en   = !rst && xfer && (id_ls_mode[5] || id_ls_mode[4]);
  assign data_sram_wen  = (data_sram_en && id_ls_mode[4]) ? wen_raw : 4'b0000;
  assign data_sram_addr = {alu_res[31:2], 2'b00};

  always_comb begin
    em_d        = '0;
    em_d.pc     = id_pc;
    em_d.result = alu_res;
    em_d.tgt    = id_target_reg;
    em_d.wen    = id_regfile_wen && !ovf;
    em_d.ls     = id_ls_mode;
    em_d.ovf    = ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      em_q  <= '0;
    end else if (xfer) begin
      vld_q <= 1'b1;
      em_q  <= em_d;
    end else if (mem_allow_in) begin
      vld_q <= 1'b0;
    end
  end

  assign exe2mem_valid       = vld_q;
  assign exe2mem_pc          = em_q.pc;
  assign exe2mem_result      = em_q.result;
  assign exe2mem_target_reg  = em_q.tgt;
  assign exe2mem_regfile_wen = em_q.wen;
  assign exe2mem_ls_mode     = em_q.ls;
  assign exe2mem_addr_low    = em_q.result[1:0];
  assign exe2mem_ovf         = em_q.ovf;

  // r0 never forwards, so consumers see zero without a special case
  assign fwd_hit      = vld_q && em_q.wen && (em_q.tgt != 5'd0);
  assign exe_fwd_tag  = fwd_hit ? {em_q.ls[5], em_q.tgt} : 6'b0;
  assign exe_fwd_data = fwd_hit ? em_q.result : 32'b0;
endmodule
